pin_arbiter: RTL and testbench
==============================

PIN_ARBITER -- requirements
Module: pin_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 8: number of requesters (cogs).
REQ-002 SHALL have parameter NLANES, default 4: number of 8-pin lanes; lane k covers pins 8k+7..8k.
REQ-003 SHALL have parameter TURN, default 2, range 1..15: Hi-Z turnaround cycles after each ownership change.
REQ-004 SHALL have parameter MAX_HOLD, default 0, range 0..65535: 0 = unlimited hold, else the forced-revoke limit in cycles.
REQ-005 SHALL have port clock_160  in  1: sole clock; all state updates on rising edge.
REQ-006 SHALL have port res  in  1: reset, asynchronous, active-high.
REQ-007 SHALL have port req  in  NREQ*NLANES: bit r*NLANES+k = requester r wants lane k.
REQ-008 SHALL have port req_out  in  NREQ*32: per-requester pin output values, bits r*32+31..r*32.
REQ-009 SHALL have port req_dir  in  NREQ*32: per-requester pin directions, 1 = drive.
REQ-010 SHALL have port grant  out  NREQ*NLANES: registered, same bit layout as req.
REQ-011 SHALL have port pin_out  out  32: registered, to pad tristate logic.
REQ-012 SHALL have port pin_dir  out  32: registered, 1 = pad driven.
REQ-013 SHALL have port lane_busy  out  NLANES: 1 when lane state is not IDLE.

Function
REQ-014 Each lane SHALL run an independent FSM with states IDLE, OWNED, TURN and its own round-robin pointer ptr (0..NREQ-1).
REQ-015 IDLE with any req for the lane: next edge -> OWNED; owner = first requester with req set, searching ptr, ptr+1, ... mod NREQ; grant for owner goes high at that edge.
REQ-016 IDLE with no request: SHALL stay IDLE, grant 0.
REQ-017 At most one grant bit per lane SHALL be high in any cycle.
REQ-018 OWNED with owner req still high and no revoke: SHALL stay OWNED; requests from other requesters are ignored.
REQ-019 OWNED with owner req low: next edge -> TURN; grant drops; ptr = (owner+1) mod NREQ.
REQ-020 Revoke: if MAX_HOLD != 0, a per-lane 16-bit hold counter SHALL increment each OWNED cycle in which another requester has req set for the lane; it holds its value otherwise.
REQ-021 When the hold counter equals MAX_HOLD, the next edge SHALL move the lane to TURN exactly as in REQ-019; the counter clears on every entry to OWNED.
REQ-022 TURN SHALL last exactly TURN cycles, counted by a 4-bit counter, then go to IDLE; requests during TURN are held pending, not granted.
REQ-023 A revoked owner SHALL compete again only through normal round-robin order.
REQ-024 pin_out/pin_dir lane k SHALL register each edge the owner's req_out/req_dir lane-k bits if the lane was OWNED in the preceding cycle, else 8'h00 for both.
REQ-025 Latency: req high in cycle N (lane IDLE) -> grant high at edge N+1 -> owner pins visible at edge N+2.
REQ-026 Release: req low in cycle M -> grant low at edge M+1 -> pin_dir lane 0 at edge M+2.
REQ-027 A single requester SHALL be able to own several lanes at once; lanes never interact.

Reset
REQ-028 res high SHALL immediately (asynchronously) force grant=0, pin_out=0, pin_dir=0, lane_busy=0, every FSM to IDLE, every ptr=0 and all counters=0, including mid-ownership.
REQ-029 After res deasserts, the first arbitration SHALL occur at the first rising edge with res low.

Verification
REQ-030 Reset release, requesters 0..7 all raise req lane 0 in one cycle -> grant r0 at next edge; each owner holds 3 cycles then drops -> order 0,1,...,7, each transfer separated by TURN=2 idle cycles, pin_dir lane 0 = 0 during each gap.
REQ-031 r3 owns lane 2 with req_dir=32'h00FF0000, req_out=32'h00A50000 -> pin_dir=32'h00FF0000, pin_out=32'h00A50000 two edges after req; other lanes 0.
REQ-032 MAX_HOLD=4: r1 holds lane 1 indefinitely, r5 requests -> r1 grant drops after 4 contended cycles, TURN, then r5 granted; r1 regains only after r5 releases.
REQ-033 r2 owns lanes 0 and 3, r6 requests lane 0 -> lane 3 unaffected; r6 granted only after r2 drops lane 0.
REQ-034 res pulsed during OWNED -> grant, pin_dir and lane_busy zero with no clock edge; after release, r0 wins simultaneous requests (ptr reset).
REQ-035 Bench SHALL check REQ-017 (single grant per lane) every cycle with random req traffic.

Source files
------------

// File: rtl/pin_arbiter.sv
// rtl/pin_arbiter.sv - per-lane round-robin arbiter muxing requester pin drive onto shared 8-pin lanes
module pin_arbiter #(
    parameter int NREQ     = 8,
    parameter int NLANES   = 4,
    parameter int TURN     = 2,
    parameter int MAX_HOLD = 0
) (
    input  logic                     clock_160,
    input  logic                     res,
    input  logic [NREQ*NLANES-1:0]   req,
    input  logic [NREQ*32-1:0]       req_out,
    input  logic [NREQ*32-1:0]       req_dir,
    output logic [NREQ*NLANES-1:0]   grant,
    output logic [31:0]              pin_out,
    output logic [31:0]              pin_dir,
    output logic [NLANES-1:0]        lane_busy
);

    localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] HOLD_LIM  = 16'(MAX_HOLD);
    localparam logic [3:0]  TURN_LAST = 4'(TURN - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWNED = 2'd1,
        S_TURN  = 2'd2
    } lane_state_e;

    lane_state_e state_q [NLANES];
    lane_state_e state_d [NLANES];
    logic [PW-1:0] ptr_q   [NLANES];
    logic [PW-1:0] ptr_d   [NLANES];
    logic [PW-1:0] owner_q [NLANES];
    logic [PW-1:0] owner_d [NLANES];
    logic [15:0]   hold_q  [NLANES];
    logic [15:0]   hold_d  [NLANES];
    logic [3:0]    tcnt_q  [NLANES];
    logic [3:0]    tcnt_d  [NLANES];

    logic [NREQ*NLANES-1:0] grant_q;
    logic [NREQ*NLANES-1:0] grant_d;
    logic [31:0]            pin_out_q;
    logic [31:0]            pin_out_d;
    logic [31:0]            pin_dir_q;
    logic [31:0]            pin_dir_d;

    // Per-lane next-state: round-robin pick, hold/revoke, turnaround, and owner pin capture
    always_comb begin
        logic [NREQ-1:0] lane_req;
        logic [NREQ-1:0] others;
        logic            found;
        logic [PW-1:0]   pick;
        int              cand;

        lane_req  = '0;
        others    = '0;
        found     = 1'b0;
        pick      = '0;
        cand      = 0;
        grant_d   = '0;
        pin_out_d = '0;
        pin_dir_d = '0;

        for (int k = 0; k < NLANES; k++) begin
            state_d[k] = state_q[k];
            ptr_d[k]   = ptr_q[k];
            owner_d[k] = owner_q[k];
            hold_d[k]  = hold_q[k];
            tcnt_d[k]  = tcnt_q[k];

            for (int r = 0; r < NREQ; r++) begin
                lane_req[r] = req[r*NLANES + k];
            end

            // first requester at or after the lane pointer, wrapping
            found = 1'b0;
            pick  = ptr_q[k];
            for (int i = 0; i < NREQ; i++) begin
                cand = (int'(ptr_q[k]) + i) % NREQ;
                if (!found && lane_req[cand]) begin
                    found = 1'b1;
                    pick  = PW'(cand);
                end
            end

            others              = lane_req;
            others[owner_q[k]]  = 1'b0;

            case (state_q[k])
                S_IDLE: begin
                    if (found) begin
                        state_d[k] = S_OWNED;
                        owner_d[k] = pick;
                        hold_d[k]  = '0;
                    end
                end
                S_OWNED: begin
                    if (!lane_req[owner_q[k]] ||
                        ((MAX_HOLD != 0) && (hold_q[k] == HOLD_LIM))) begin
                        state_d[k] = S_TURN;
                        tcnt_d[k]  = '0;
                        ptr_d[k]   = (int'(owner_q[k]) == NREQ - 1) ? '0 : owner_q[k] + 1'b1;
                    end else if ((MAX_HOLD != 0) && (|others)) begin
                        hold_d[k] = hold_q[k] + 16'd1;
                    end
                end
                S_TURN: begin
                    if (tcnt_q[k] == TURN_LAST) begin
                        state_d[k] = S_IDLE;
                        tcnt_d[k]  = '0;
                    end else begin
                        tcnt_d[k] = tcnt_q[k] + 4'd1;
                    end
                end
                default: begin
                    state_d[k] = S_IDLE;
                end
            endcase

            if (state_d[k] == S_OWNED) begin
                grant_d[int'(owner_d[k])*NLANES + k] = 1'b1;
            end

            // pins follow the owner of the cycle just ending, so they trail grant by one edge
            if (state_q[k] == S_OWNED) begin
                pin_out_d[k*8 +: 8] = req_out[int'(owner_q[k])*32 + k*8 +: 8];
                pin_dir_d[k*8 +: 8] = req_dir[int'(owner_q[k])*32 + k*8 +: 8];
            end
        end
    end

    // State, pointer, counter and output registers with asynchronous clear
    always_ff @(posedge clock_160 or posedge res) begin
        if (res) begin
            for (int k = 0; k < NLANES; k++) begin
                state_q[k] <= S_IDLE;
                ptr_q[k]   <= '0;
                owner_q[k] <= '0;
                hold_q[k]  <= '0;
                tcnt_q[k]  <= '0;
            end
            grant_q   <= '0;
            pin_out_q <= '0;
            pin_dir_q <= '0;
        end else begin
            for (int k = 0; k < NLANES; k++) begin
                state_q[k] <= state_d[k];
                ptr_q[k]   <= ptr_d[k];
                owner_q[k] <= owner_d[k];
                hold_q[k]  <= hold_d[k];
                tcnt_q[k]  <= tcnt_d[k];
            end
            grant_q   <= grant_d;
            pin_out_q <= pin_out_d;
            pin_dir_q <= pin_dir_d;
        end
    end

    // A lane is busy whenever it is owned or turning around
    always_comb begin
        lane_busy = '0;
        for (int k = 0; k < NLANES; k++) begin
            lane_busy[k] = (state_q[k] != S_IDLE);
        end
    end

    assign grant   = grant_q;
    assign pin_out = pin_out_q;
    assign pin_dir = pin_dir_q;

endmodule

// File: tb/tb_pin_arbiter.sv
// tb/tb_pin_arbiter.sv - directed and table-driven bench for pin_arbiter
module tb_pin_arbiter;

    logic         clk = 1'b0;
    logic         res = 1'b1;
    logic [31:0]  req = '0;
    logic [255:0] req_out = '0;
    logic [255:0] req_dir = '0;
    logic [31:0]  grant;
    logic [31:0]  pin_out;
    logic [31:0]  pin_dir;
    logic [3:0]   lane_busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] req;
        logic [31:0] grant;
        logic [3:0]  busy;
    } vec_t;

    vec_t tbl [14];

    pin_arbiter #(
        .NREQ(8),
        .NLANES(4),
        .TURN(2),
        .MAX_HOLD(4)
    ) dut (
        .clock_160(clk),
        .res(res),
        .req(req),
        .req_out(req_out),
        .req_dir(req_dir),
        .grant(grant),
        .pin_out(pin_out),
        .pin_dir(pin_dir),
        .lane_busy(lane_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rst_pulse();
        #3;
        res = 1'b1;
        #1;
        @(posedge clk);
        #1;
        res = 1'b0;
        req = '0;
    endtask

    function automatic logic lanes_ok(input logic [31:0] g);
        logic [7:0] v;
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 8; r++) v[r] = g[r*4 + k];
            if (!$onehot0(v)) return 1'b0;
        end
        return 1'b1;
    endfunction

    initial begin
        tbl[0]  = '{32'h0, 32'h0, 4'b0000};
        tbl[1]  = '{(32'h1 << 14) | (32'h1 << 21), (32'h1 << 14) | (32'h1 << 21), 4'b0110};
        tbl[2]  = '{(32'h1 << 14) | (32'h1 << 21) | (32'h1 << 1), (32'h1 << 14) | (32'h1 << 21), 4'b0110};
        tbl[3]  = '{(32'h1 << 14) | (32'h1 << 1), 32'h1 << 14, 4'b0110};
        tbl[4]  = '{(32'h1 << 14) | (32'h1 << 1), 32'h1 << 14, 4'b0110};
        tbl[5]  = '{(32'h1 << 14) | (32'h1 << 1), 32'h1 << 14, 4'b0100};
        tbl[6]  = '{(32'h1 << 14) | (32'h1 << 1), (32'h1 << 14) | (32'h1 << 1), 4'b0110};
        tbl[7]  = '{32'h0, 32'h0, 4'b0110};
        tbl[8]  = '{32'h0, 32'h0, 4'b0110};
        tbl[9]  = '{32'h0, 32'h0, 4'b0000};
        tbl[10] = '{(32'h1 << 1) | (32'h1 << 5) | (32'h1 << 2) | (32'h1 << 30), (32'h1 << 5) | (32'h1 << 30), 4'b0110};
        tbl[11] = '{32'h0, 32'h0, 4'b0110};
        tbl[12] = '{32'h0, 32'h0, 4'b0110};
        tbl[13] = '{32'h0, 32'h0, 4'b0000};

        // reset state
        tick();
        tick();
        chk("rst_grant", grant, 32'h0);
        chk("rst_pin_dir", pin_dir, 32'h0);
        chk("rst_pin_out", pin_out, 32'h0);
        chk("rst_busy", {28'h0, lane_busy}, 32'h0);
        res = 1'b0;

        // table vectors: arbitration, pointer rotation, turnaround
        for (int i = 0; i < 14; i++) begin
            req = tbl[i].req;
            tick();
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d_busy", i), {28'h0, lane_busy}, {28'h0, tbl[i].busy});
        end

        // all eight requesters on lane 0, each holds three cycles
        rst_pulse();
        for (int r = 0; r < 8; r++) begin
            req_dir[r*32 +: 32] = 32'h0000_00FF;
            req_out[r*32 +: 32] = 32'h10 + r;
        end
        req = 32'h1111_1111;
        tick();
        for (int e = 0; e < 8; e++) begin
            chk($sformatf("rr%0d_grant", e), grant, 32'h1 << (e*4));
            chk($sformatf("rr%0d_dir_pre", e), {24'h0, pin_dir[7:0]}, 32'h0);
            tick();
            chk($sformatf("rr%0d_dir", e), {24'h0, pin_dir[7:0]}, 32'hFF);
            chk($sformatf("rr%0d_out", e), {24'h0, pin_out[7:0]}, 32'h10 + e);
            tick();
            chk($sformatf("rr%0d_hold", e), grant, 32'h1 << (e*4));
            req[e*4] = 1'b0;
            tick();
            chk($sformatf("rr%0d_rel_grant", e), grant, 32'h0);
            chk($sformatf("rr%0d_rel_dir", e), {24'h0, pin_dir[7:0]}, 32'hFF);
            tick();
            chk($sformatf("rr%0d_gap1_grant", e), grant, 32'h0);
            chk($sformatf("rr%0d_gap1_dir", e), {24'h0, pin_dir[7:0]}, 32'h0);
            chk($sformatf("rr%0d_gap1_busy", e), {31'h0, lane_busy[0]}, 32'h1);
            tick();
            chk($sformatf("rr%0d_gap2_grant", e), grant, 32'h0);
            chk($sformatf("rr%0d_gap2_dir", e), {24'h0, pin_dir[7:0]}, 32'h0);
            chk($sformatf("rr%0d_gap2_busy", e), {31'h0, lane_busy[0]}, 32'h0);
            tick();
        end
        chk("rr_end_grant", grant, 32'h0);

        // r3 drives lane 2 pins
        rst_pulse();
        req_dir = '0;
        req_out = '0;
        req_dir[3*32 +: 32] = 32'h00FF_0000;
        req_out[3*32 +: 32] = 32'h00A5_0000;
        req_dir[4*32 +: 32] = 32'hFFFF_FFFF;
        req_out[4*32 +: 32] = 32'hFFFF_FFFF;
        req = 32'h1 << 14;
        tick();
        chk("pin_grant", grant, 32'h1 << 14);
        chk("pin_dir_early", pin_dir, 32'h0);
        tick();
        chk("pin_dir", pin_dir, 32'h00FF_0000);
        chk("pin_out", pin_out, 32'h00A5_0000);

        // forced revoke of r1 on lane 1 by contending r5
        rst_pulse();
        req = 32'h1 << 5;
        tick();
        chk("rev_grant_r1", grant, 32'h1 << 5);
        req = (32'h1 << 5) | (32'h1 << 21);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("rev_hold%0d", i), grant, 32'h1 << 5);
        end
        tick();
        chk("rev_drop", grant, 32'h0);
        tick();
        chk("rev_turn", grant, 32'h0);
        tick();
        chk("rev_idle_grant", grant, 32'h0);
        chk("rev_idle_busy", {28'h0, lane_busy}, 32'h0);
        tick();
        chk("rev_grant_r5", grant, 32'h1 << 21);
        tick();
        chk("rev_r5_hold", grant, 32'h1 << 21);
        req = 32'h1 << 5;
        tick();
        chk("rev_r5_rel", grant, 32'h0);
        tick();
        tick();
        chk("rev_r1_wait", grant, 32'h0);
        tick();
        chk("rev_r1_again", grant, 32'h1 << 5);

        // r2 owns lanes 0 and 3; r6 contends lane 0 only
        rst_pulse();
        req = (32'h1 << 8) | (32'h1 << 11);
        tick();
        chk("multi_grant", grant, (32'h1 << 8) | (32'h1 << 11));
        req = (32'h1 << 8) | (32'h1 << 11) | (32'h1 << 24);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("multi_hold%0d", i), grant, (32'h1 << 8) | (32'h1 << 11));
        end
        req = (32'h1 << 11) | (32'h1 << 24);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("multi_l3_only%0d", i), grant, 32'h1 << 11);
        end
        tick();
        chk("multi_r6", grant, (32'h1 << 11) | (32'h1 << 24));

        // asynchronous reset mid-ownership, then pointer restarts at r0
        req_dir[2*32 +: 32] = 32'hFFFF_FFFF;
        tick();
        chk("async_pre_dir", {24'h0, pin_dir[31:24]}, 32'hFF);
        #3;
        res = 1'b1;
        #1;
        chk("async_grant", grant, 32'h0);
        chk("async_pin_dir", pin_dir, 32'h0);
        chk("async_pin_out", pin_out, 32'h0);
        chk("async_busy", {28'h0, lane_busy}, 32'h0);
        @(posedge clk);
        #1;
        res = 1'b0;
        req = (32'h1 << 0) | (32'h1 << 12);
        tick();
        chk("async_ptr_r0", grant, 32'h1);

        // random traffic, at most one grant per lane every cycle
        rst_pulse();
        for (int i = 0; i < 600; i++) begin
            req = $urandom;
            tick();
            chk("single_grant", {31'h0, lanes_ok(grant)}, 32'h1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
